// File: rtl/hazard_scoreboard_pkg.sv
// Shared scoreboard constants: default sizing, the register-0 index and
// the unknown-latency code helper, shared with decode.
package hazard_scoreboard_pkg;

   localparam int unsigned NREGS_DEF = 32;
   localparam int unsigned AW_DEF    = 5;
   localparam int unsigned LAT_W_DEF = 3;
   localparam int unsigned ZERO      = 0;

   // All-ones latency code marks a producer completed by a done strobe.
   function automatic int unsigned lat_unk(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: latency countdown plus unknown-latency flag.
// Ports: clk, rst_n, load/load_lat (accepted issue), done; cnt, unk, pend.
module hazard_sb_entry
   import hazard_scoreboard_pkg::*;
#(
   parameter int unsigned LAT_W = LAT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [LAT_W-1:0] load_lat,
   input  logic             done,
   output logic [LAT_W-1:0] cnt,
   output logic             unk,
   output logic             pend
);

   localparam logic [LAT_W-1:0] LAT_UNK = LAT_W'(lat_unk(LAT_W));

   // An issue load overrides both the countdown and a same-cycle done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         unk <= 1'b0;
      end else if (load) begin
         if (load_lat == LAT_UNK) begin
            unk <= 1'b1;
            cnt <= '0;
         end else begin
            unk <= 1'b0;
            cnt <= load_lat;
         end
      end else begin
         if (cnt != '0)
            cnt <= cnt - 1'b1;
         if (done)
            unk <= 1'b0;
      end
   end

   assign pend = (cnt != '0) | unk;

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register pending-result scoreboard for decode: RAW and WAW stall.
// Ports: issue_* / rs_* / rt_* / done_* in; stall, rs_pending, rt_pending,
// busy out. HAZARD_SCOREBOARD_STATS_EN adds stall_cycles, stall_events.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int unsigned NREGS = NREGS_DEF,
   parameter int unsigned AW    = AW_DEF,
   parameter int unsigned LAT_W = LAT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             issue_valid,
   input  logic [AW-1:0]    rs_addr,
   input  logic             rs_used,
   input  logic [AW-1:0]    rt_addr,
   input  logic             rt_used,
   input  logic             issue_we,
   input  logic [AW-1:0]    issue_waddr,
   input  logic [LAT_W-1:0] issue_lat,
   input  logic             done_valid,
   input  logic [AW-1:0]    done_addr,
   output logic             stall,
   output logic             rs_pending,
   output logic             rt_pending,
   output logic             busy
`ifdef HAZARD_SCOREBOARD_STATS_EN
   ,
   output logic [31:0]      stall_cycles,
   output logic [31:0]      stall_events
`endif
);

   localparam logic [LAT_W-1:0] LAT_UNK = LAT_W'(lat_unk(LAT_W));

   logic [LAT_W-1:0] cnt [NREGS];
   logic [NREGS-1:0] unk;
   logic [NREGS-1:0] pend;
   logic             accept;
   logic             waw;

   assign cnt[ZERO]  = '0;
   assign unk[ZERO]  = 1'b0;
   assign pend[ZERO] = 1'b0;

   for (genvar r = 1; r < NREGS; r++) begin : g_ent
      logic load_r;
      logic done_r;
      assign load_r = accept & issue_we & (issue_waddr == AW'(r));
      assign done_r = done_valid & (done_addr == AW'(r));
      hazard_sb_entry #(.LAT_W(LAT_W)) u_ent (
         .clk      (clk),
         .rst_n    (rst_n),
         .load     (load_r),
         .load_lat (issue_lat),
         .done     (done_r),
         .cnt      (cnt[r]),
         .unk      (unk[r]),
         .pend     (pend[r])
      );
   end

   // A newer write must not land before an older, slower one.
   always_comb begin
      waw = 1'b0;
      if (issue_lat == LAT_UNK)
         waw = pend[issue_waddr];
      else
         waw = unk[issue_waddr] | (cnt[issue_waddr] > issue_lat);
   end

   assign rs_pending = rs_used & pend[rs_addr];
   assign rt_pending = rt_used & pend[rt_addr];
   assign stall  = issue_valid
                 & (rs_pending | rt_pending | (issue_we & waw));
   assign accept = issue_valid & ~stall;
   assign busy   = |pend;

`ifdef HAZARD_SCOREBOARD_STATS_EN
   logic stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q      <= 1'b0;
         stall_cycles <= '0;
         stall_events <= '0;
      end else begin
         stall_q <= stall;
         if (stall && stall_cycles != '1)
            stall_cycles <= stall_cycles + 32'd1;
         if (stall && !stall_q && stall_events != '1)
            stall_events <= stall_events + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: ready-time model plus
// directed load-use, MUL, DIV, WAW, $0 and async-reset scenarios.
module tb_hazard_scoreboard;

   localparam int LUNK = 7;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       issue_valid = 0;
   logic [4:0] rs_addr = 0;
   logic       rs_used = 0;
   logic [4:0] rt_addr = 0;
   logic       rt_used = 0;
   logic       issue_we = 0;
   logic [4:0] issue_waddr = 0;
   logic [2:0] issue_lat = 0;
   logic       done_valid = 0;
   logic [4:0] done_addr = 0;
   logic       stall, rs_pending, rt_pending, busy;
`ifdef HAZARD_SCOREBOARD_STATS_EN
   logic [31:0] stall_cycles, stall_events;
`endif

   hazard_scoreboard dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .issue_valid (issue_valid),
      .rs_addr     (rs_addr),
      .rs_used     (rs_used),
      .rt_addr     (rt_addr),
      .rt_used     (rt_used),
      .issue_we    (issue_we),
      .issue_waddr (issue_waddr),
      .issue_lat   (issue_lat),
      .done_valid  (done_valid),
      .done_addr   (done_addr),
      .stall       (stall),
      .rs_pending  (rs_pending),
      .rt_pending  (rt_pending),
      .busy        (busy)
`ifdef HAZARD_SCOREBOARD_STATS_EN
      ,
      .stall_cycles(stall_cycles),
      .stall_events(stall_events)
`endif
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Model: absolute cycle at which each result becomes forwardable.
   longint cyc = 0;
   longint ready [32];
   bit     m_unk [32];
   int     m_sc = 0, m_se = 0;
   bit     m_prev = 0;

   function automatic bit m_pend(input int r);
      return (r != 0) && (m_unk[r] || cyc < ready[r]);
   endfunction

   function automatic int m_left(input int r);
      return (r != 0 && cyc < ready[r]) ? int'(ready[r] - cyc) : 0;
   endfunction

   function automatic bit m_stall();
      bit raw, waw;
      raw = (rs_used && m_pend(rs_addr)) || (rt_used && m_pend(rt_addr));
      if (issue_lat == 3'(LUNK))
         waw = m_pend(issue_waddr);
      else
         waw = m_unk[issue_waddr] || (m_left(issue_waddr) > issue_lat);
      return issue_valid && (raw || (issue_we && waw));
   endfunction

   function automatic bit m_busy();
      for (int r = 1; r < 32; r++)
         if (m_pend(r)) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < 32; r++) begin
            ready[r] = 0;
            m_unk[r] = 0;
         end
         cyc = 0;
         m_sc = 0;
         m_se = 0;
         m_prev = 0;
      end else begin
         bit s;
         s = m_stall();
         if (s) m_sc++;
         if (s && !m_prev) m_se++;
         m_prev = s;
         cyc++;
         if (done_valid) m_unk[done_addr] = 0;
         if (!s && issue_valid && issue_we && issue_waddr != 0) begin
            if (issue_lat == 3'(LUNK)) begin
               m_unk[issue_waddr] = 1;
               ready[issue_waddr] = cyc;
            end else begin
               m_unk[issue_waddr] = 0;
               ready[issue_waddr] = cyc + longint'(issue_lat);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("stall", int'(stall), int'(m_stall()));
         chk("rs_pending", int'(rs_pending),
             int'(rs_used && m_pend(rs_addr)));
         chk("rt_pending", int'(rt_pending),
             int'(rt_used && m_pend(rt_addr)));
         chk("busy", int'(busy), int'(m_busy()));
`ifdef HAZARD_SCOREBOARD_STATS_EN
         chk("stall_cycles", int'(stall_cycles), m_sc);
         chk("stall_events", int'(stall_events), m_se);
`endif
      end
   end

   // Drive one cycle; report stall/rt_pending/busy seen mid-cycle.
   task automatic cyc_in(input bit v, input int rs, input bit rsu,
                         input int rt, input bit rtu, input bit we,
                         input int wa, input int lat, input bit dv,
                         input int da, output bit st, output bit rtp,
                         output bit bz);
      issue_valid = v;
      rs_addr = 5'(rs);  rs_used = rsu;
      rt_addr = 5'(rt);  rt_used = rtu;
      issue_we = we;     issue_waddr = 5'(wa);
      issue_lat = 3'(lat);
      done_valid = dv;   done_addr = 5'(da);
      @(negedge clk);
      st = stall; rtp = rt_pending; bz = busy;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bit a, b, c;
      for (int i = 0; i < n; i++)
         cyc_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, a, b, c);
   endtask

   initial begin
      bit st, rtp, bz;
      #12;
      chk("reset_stall", int'(stall), 0);
      chk("reset_busy", int'(busy), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Load-use: one stall cycle
      cyc_in(1, 0, 0, 0, 0, 1, 8, 1, 0, 0, st, rtp, bz);
      chk("lu_issue", int'(st), 0);
      cyc_in(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, st, rtp, bz);
      chk("lu_stall", int'(st), 1);
      cyc_in(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, st, rtp, bz);
      chk("lu_accept", int'(st), 0);
      idle(1);

      // MUL lat=3: three stall cycles, rt_pending drops on the 4th
      cyc_in(1, 0, 0, 0, 0, 1, 9, 3, 0, 0, st, rtp, bz);
      for (int i = 0; i < 3; i++) begin
         cyc_in(1, 0, 0, 9, 1, 0, 0, 0, 0, 0, st, rtp, bz);
         chk("mul_stall", int'(st), 1);
      end
      cyc_in(1, 0, 0, 9, 1, 0, 0, 0, 0, 0, st, rtp, bz);
      chk("mul_rt_drop", int'(rtp), 0);
      chk("mul_accept", int'(st), 0);
      idle(1);

      // DIV unknown latency, finished by done
      cyc_in(1, 0, 0, 0, 0, 1, 10, LUNK, 0, 0, st, rtp, bz);
      for (int i = 0; i < 5; i++) begin
         cyc_in(1, 10, 1, 0, 0, 0, 0, 0, 0, 0, st, rtp, bz);
         chk("div_wait", int'(st), 1);
      end
      cyc_in(1, 10, 1, 0, 0, 0, 0, 0, 1, 10, st, rtp, bz);
      chk("div_done_cycle", int'(st), 1);
      cyc_in(1, 10, 1, 0, 0, 0, 0, 0, 0, 0, st, rtp, bz);
      chk("div_after_done", int'(st), 0);
      // stray done to an idle register and to $0
      cyc_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 12, st, rtp, bz);
      cyc_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, st, rtp, bz);
      chk("idle_busy", int'(bz), 0);

      // WAW: lat3 then lat1 to $11
      cyc_in(1, 0, 0, 0, 0, 1, 11, 3, 0, 0, st, rtp, bz);
      cyc_in(1, 0, 0, 0, 0, 1, 11, 1, 0, 0, st, rtp, bz);
      chk("waw_stall1", int'(st), 1);
      cyc_in(1, 0, 0, 0, 0, 1, 11, 1, 0, 0, st, rtp, bz);
      chk("waw_stall2", int'(st), 1);
      cyc_in(1, 0, 0, 0, 0, 1, 11, 1, 0, 0, st, rtp, bz);
      chk("waw_accept", int'(st), 0);
      cyc_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st, rtp, bz);
      chk("waw_pend_1more", int'(bz), 1);
      cyc_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st, rtp, bz);
      chk("waw_clear", int'(bz), 0);

      // Unknown-latency write over a pending known one
      cyc_in(1, 0, 0, 0, 0, 1, 13, 2, 0, 0, st, rtp, bz);
      cyc_in(1, 0, 0, 0, 0, 1, 13, LUNK, 0, 0, st, rtp, bz);
      chk("waw_unk_stall", int'(st), 1);
      idle(3);

      // $0 is never pending
      cyc_in(1, 0, 0, 0, 0, 1, 0, 3, 0, 0, st, rtp, bz);
      cyc_in(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, st, rtp, bz);
      chk("zero_stall", int'(st), 0);
      chk("zero_busy", int'(bz), 0);

      // Async reset mid-operation
      cyc_in(1, 0, 0, 0, 0, 1, 10, LUNK, 0, 0, st, rtp, bz);
      cyc_in(1, 0, 0, 0, 0, 1, 9, 3, 0, 0, st, rtp, bz);
      idle(1);
      issue_valid = 1; rs_addr = 10; rs_used = 1;
      issue_we = 0; done_valid = 0;
      #2;
      chk("pre_rst_stall", int'(stall), 1);
      chk("pre_rst_busy", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("rst_stall", int'(stall), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_rs_pending", int'(rs_pending), 0);
`ifdef HAZARD_SCOREBOARD_STATS_EN
      chk("rst_stall_cycles", int'(stall_cycles), 0);
      chk("rst_stall_events", int'(stall_events), 0);
`endif
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
